// File: rtl/date_counter.sv
// rtl/date_counter.sv - calendar day/month/year counter advanced on the hour 23->0 rollover
// Optional day-of-week tracking is enabled by defining DATE_COUNTER_DOW_EN.
module date_counter #(
  parameter int YEARRES  = 12,
  parameter int YEARBASE = 0,
  parameter int RST_YEAR = 0,
  parameter int RST_DOW  = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [4:0]         hour_in,
  input  logic               date_ld,
  input  logic [YEARRES+8:0] date_in,
  input  logic [2:0]         dow_in,
  output logic [YEARRES+8:0] date_out,
  output logic [2:0]         dow_out,
  output logic               new_day,
  output logic               new_month,
  output logic               new_year,
  output logic               load_err
);

  localparam int LW = ((YEARRES > 12) ? YEARRES : 12) + 1;

  logic [4:0]         r_day;
  logic [3:0]         r_month;
  logic [YEARRES-1:0] r_year;
  logic [4:0]         r_hour_prev;
  logic               r_new_day;
  logic               r_new_month;
  logic               r_new_year;
  logic               r_load_err;

  logic [4:0]         w_ld_day;
  logic [3:0]         w_ld_month;
  logic [YEARRES-1:0] w_ld_year;
  logic [4:0]         w_len;
  logic [4:0]         w_ld_len;
  logic               w_tick;
  logic               w_day_wrap;
  logic               w_month_wrap;
  logic               w_ld_ok;

  // Absolute year is widened so YEARBASE plus the largest offset cannot overflow.
  function automatic logic f_leap(input logic [YEARRES-1:0] yr);
    logic [LW-1:0] y;
    y = LW'(yr) + LW'(YEARBASE);
    return ((y[1:0] == 2'd0) && ((y % LW'(100)) != '0)) || ((y % LW'(400)) == '0);
  endfunction

  function automatic logic [4:0] f_len(input logic [3:0] m, input logic [YEARRES-1:0] yr);
    case (m)
      4'd2:                     return f_leap(yr) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:  return 5'd30;
      default:                  return 5'd31;
    endcase
  endfunction

  assign w_ld_day   = date_in[YEARRES+8:YEARRES+4];
  assign w_ld_month = date_in[YEARRES+3:YEARRES];
  assign w_ld_year  = date_in[YEARRES-1:0];

  assign w_len        = f_len(r_month, r_year);
  assign w_ld_len     = f_len(w_ld_month, w_ld_year);
  assign w_tick       = (r_hour_prev == 5'd23) && (hour_in == 5'd0);
  assign w_day_wrap   = (r_day >= w_len);
  assign w_month_wrap = (r_month >= 4'd12);

`ifdef DATE_COUNTER_DOW_EN
  assign w_ld_ok = (w_ld_month >= 4'd1) && (w_ld_month <= 4'd12) &&
                   (w_ld_day != 5'd0) && (w_ld_day <= w_ld_len) && (dow_in <= 3'd6);
`else
  assign w_ld_ok = (w_ld_month >= 4'd1) && (w_ld_month <= 4'd12) &&
                   (w_ld_day != 5'd0) && (w_ld_day <= w_ld_len);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_day       <= 5'd1;
      r_month     <= 4'd1;
      r_year      <= YEARRES'(RST_YEAR);
      r_hour_prev <= 5'd0;
      r_new_day   <= 1'b0;
      r_new_month <= 1'b0;
      r_new_year  <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_hour_prev <= hour_in;
      r_new_day   <= 1'b0;
      r_new_month <= 1'b0;
      r_new_year  <= 1'b0;
      r_load_err  <= 1'b0;
      // A load in the rollover cycle takes priority and swallows the tick.
      if (date_ld) begin
        if (w_ld_ok) begin
          r_day   <= w_ld_day;
          r_month <= w_ld_month;
          r_year  <= w_ld_year;
        end else begin
          r_load_err <= 1'b1;
        end
      end else if (w_tick) begin
        r_new_day <= 1'b1;
        if (!w_day_wrap) begin
          r_day <= r_day + 5'd1;
        end else begin
          r_day       <= 5'd1;
          r_new_month <= 1'b1;
          if (!w_month_wrap) begin
            r_month <= r_month + 4'd1;
          end else begin
            r_month    <= 4'd1;
            r_year     <= r_year + 1'b1;
            r_new_year <= 1'b1;
          end
        end
      end
    end
  end

`ifdef DATE_COUNTER_DOW_EN
  logic [2:0] r_dow;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dow <= 3'(RST_DOW);
    end else if (date_ld) begin
      if (w_ld_ok) r_dow <= dow_in;
    end else if (w_tick) begin
      r_dow <= (r_dow >= 3'd6) ? 3'd0 : r_dow + 3'd1;
    end
  end

  assign dow_out = r_dow;
`else
  logic w_unused_dow;
  assign w_unused_dow = ^dow_in;
  assign dow_out      = 3'd0;
`endif

  assign date_out  = {r_day, r_month, r_year};
  assign new_day   = r_new_day;
  assign new_month = r_new_month;
  assign new_year  = r_new_year;
  assign load_err  = r_load_err;

endmodule

// File: tb/tb_date_counter.sv
// tb/tb_date_counter.sv - directed testbench for date_counter (YEARBASE=1900, YEARRES=12)
module tb_date_counter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  hour_in;
  logic        date_ld;
  logic [20:0] date_in;
  logic [2:0]  dow_in;
  logic [20:0] date_out;
  logic [2:0]  dow_out;
  logic        new_day, new_month, new_year, load_err;

  int n_cmp = 0;
  int n_err = 0;

  date_counter #(.YEARRES(12), .YEARBASE(1900), .RST_YEAR(0), .RST_DOW(6)) dut (
    .clk(clk), .rst_n(rst_n), .hour_in(hour_in), .date_ld(date_ld), .date_in(date_in),
    .dow_in(dow_in), .date_out(date_out), .dow_out(dow_out), .new_day(new_day),
    .new_month(new_month), .new_year(new_year), .load_err(load_err)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] pack(input int d, input int m, input int y);
    return {5'(d), 4'(m), 12'(y)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    hour_in = 5'd23; step();
    hour_in = 5'd0;  step();
  endtask

  task automatic load(input int d, input int m, input int y, input int w);
    date_in = pack(d, m, y); dow_in = 3'(w); date_ld = 1'b1;
    step();
    date_ld = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hour_in = 5'd0; date_ld = 1'b0; date_in = '0; dow_in = 3'd0;
    step(); step();
    rst_n = 1'b1;
    n_cmp++; if (date_out !== pack(1, 1, 0)) begin n_err++; $display("FAIL reset_date got %h want %h", date_out, pack(1, 1, 0)); end
    n_cmp++; if ({new_day, new_month, new_year, load_err} !== 4'b0000) begin n_err++; $display("FAIL reset_strobes got %b want 0000", {new_day, new_month, new_year, load_err}); end
`ifdef DATE_COUNTER_DOW_EN
    n_cmp++; if (dow_out !== 3'd6) begin n_err++; $display("FAIL reset_dow got %0d want 6", dow_out); end
`else
    n_cmp++; if (dow_out !== 3'd0) begin n_err++; $display("FAIL reset_dow got %0d want 0", dow_out); end
`endif
  endtask

  task automatic test_false_tick();
    hour_in = 5'd0; step();
    hour_in = 5'd5; step();
    hour_in = 5'd0; step();
    n_cmp++; if (date_out !== pack(1, 1, 0) || new_day !== 1'b0) begin n_err++; $display("FAIL jump_5_to_0 got %h/%b want %h/0", date_out, new_day, pack(1, 1, 0)); end
    hour_in = 5'd23; step();
    hour_in = 5'd7;  step();
    n_cmp++; if (date_out !== pack(1, 1, 0) || new_day !== 1'b0) begin n_err++; $display("FAIL jump_23_to_7 got %h/%b want %h/0", date_out, new_day, pack(1, 1, 0)); end
  endtask

  task automatic test_first_tick();
    hour_in = 5'd22; step();
    tick();
    n_cmp++; if (date_out !== pack(2, 1, 0)) begin n_err++; $display("FAIL first_tick_date got %h want %h", date_out, pack(2, 1, 0)); end
    n_cmp++; if ({new_day, new_month, new_year} !== 3'b100) begin n_err++; $display("FAIL first_tick_strobes got %b want 100", {new_day, new_month, new_year}); end
    hour_in = 5'd1; step();
    n_cmp++; if ({new_day, new_month, new_year} !== 3'b000) begin n_err++; $display("FAIL strobe_width got %b want 000", {new_day, new_month, new_year}); end
  endtask

  task automatic test_leap();
    load(28, 2, 100, 0);
    n_cmp++; if (date_out !== pack(28, 2, 100) || load_err !== 1'b0) begin n_err++; $display("FAIL load_2000 got %h/%b want %h/0", date_out, load_err, pack(28, 2, 100)); end
    tick();
    n_cmp++; if (date_out !== pack(29, 2, 100) || new_month !== 1'b0) begin n_err++; $display("FAIL leap_2000_29feb got %h/%b want %h/0", date_out, new_month, pack(29, 2, 100)); end
    tick();
    n_cmp++; if (date_out !== pack(1, 3, 100) || {new_day, new_month, new_year} !== 3'b110) begin n_err++; $display("FAIL leap_2000_1mar got %h/%b want %h/110", date_out, {new_day, new_month, new_year}, pack(1, 3, 100)); end
    load(28, 2, 0, 0);
    tick();
    n_cmp++; if (date_out !== pack(1, 3, 0) || {new_day, new_month, new_year} !== 3'b110) begin n_err++; $display("FAIL nonleap_1900 got %h/%b want %h/110", date_out, {new_day, new_month, new_year}, pack(1, 3, 0)); end
    load(29, 2, 0, 0);
    n_cmp++; if (date_out !== pack(1, 3, 0) || load_err !== 1'b1) begin n_err++; $display("FAIL reject_29feb1900 got %h/%b want %h/1", date_out, load_err, pack(1, 3, 0)); end
    load(29, 2, 104, 0);
    n_cmp++; if (date_out !== pack(29, 2, 104) || load_err !== 1'b0) begin n_err++; $display("FAIL accept_29feb2004 got %h/%b want %h/0", date_out, load_err, pack(29, 2, 104)); end
  endtask

  task automatic test_year_wrap();
    load(31, 12, 4095, 0);
    tick();
    n_cmp++; if (date_out !== pack(1, 1, 0)) begin n_err++; $display("FAIL year_wrap_date got %h want %h", date_out, pack(1, 1, 0)); end
    n_cmp++; if ({new_day, new_month, new_year} !== 3'b111) begin n_err++; $display("FAIL year_wrap_strobes got %b want 111", {new_day, new_month, new_year}); end
  endtask

  task automatic test_load_err();
    load(30, 4, 7, 0);
    n_cmp++; if (date_out !== pack(30, 4, 7) || load_err !== 1'b0) begin n_err++; $display("FAIL accept_30apr got %h/%b want %h/0", date_out, load_err, pack(30, 4, 7)); end
    load(31, 4, 9, 0);
    n_cmp++; if (date_out !== pack(30, 4, 7) || load_err !== 1'b1) begin n_err++; $display("FAIL reject_31apr got %h/%b want %h/1", date_out, load_err, pack(30, 4, 7)); end
    step();
    n_cmp++; if (load_err !== 1'b0) begin n_err++; $display("FAIL load_err_width got %b want 0", load_err); end
    load(0, 5, 9, 0);
    n_cmp++; if (date_out !== pack(30, 4, 7) || load_err !== 1'b1) begin n_err++; $display("FAIL reject_day0 got %h/%b want %h/1", date_out, load_err, pack(30, 4, 7)); end
    load(10, 13, 9, 0);
    n_cmp++; if (date_out !== pack(30, 4, 7) || load_err !== 1'b1) begin n_err++; $display("FAIL reject_month13 got %h/%b want %h/1", date_out, load_err, pack(30, 4, 7)); end
    load(10, 0, 9, 0);
    n_cmp++; if (date_out !== pack(30, 4, 7) || load_err !== 1'b1) begin n_err++; $display("FAIL reject_month0 got %h/%b want %h/1", date_out, load_err, pack(30, 4, 7)); end
    tick();
    n_cmp++; if (date_out !== pack(1, 5, 7) || {new_day, new_month, new_year} !== 3'b110) begin n_err++; $display("FAIL apr_to_may got %h/%b want %h/110", date_out, {new_day, new_month, new_year}, pack(1, 5, 7)); end
  endtask

  task automatic test_load_tick_collision();
    hour_in = 5'd23; step();
    hour_in = 5'd0; date_in = pack(15, 6, 20); dow_in = 3'd0; date_ld = 1'b1;
    step();
    date_ld = 1'b0;
    n_cmp++; if (date_out !== pack(15, 6, 20) || {new_day, new_month, new_year, load_err} !== 4'b0000) begin n_err++; $display("FAIL collide_load got %h/%b want %h/0000", date_out, {new_day, new_month, new_year, load_err}, pack(15, 6, 20)); end
    hour_in = 5'd5; step();
    tick();
    n_cmp++; if (date_out !== pack(16, 6, 20) || new_day !== 1'b1) begin n_err++; $display("FAIL collide_next_tick got %h/%b want %h/1", date_out, new_day, pack(16, 6, 20)); end
  endtask

  task automatic test_back_to_back();
    hour_in = 5'd3;
    date_ld = 1'b1; dow_in = 3'd0;
    date_in = pack(3, 7, 9); step();
    n_cmp++; if (date_out !== pack(3, 7, 9) || {new_day, load_err} !== 2'b00) begin n_err++; $display("FAIL held_load_1 got %h/%b want %h/00", date_out, {new_day, load_err}, pack(3, 7, 9)); end
    date_in = pack(4, 8, 10); step();
    n_cmp++; if (date_out !== pack(4, 8, 10) || {new_day, load_err} !== 2'b00) begin n_err++; $display("FAIL held_load_2 got %h/%b want %h/00", date_out, {new_day, load_err}, pack(4, 8, 10)); end
    date_ld = 1'b0;
  endtask

  task automatic test_reset_mid();
    hour_in = 5'd23; step();
    hour_in = 5'd0; rst_n = 1'b0; step();
    rst_n = 1'b1;
    n_cmp++; if (date_out !== pack(1, 1, 0) || new_day !== 1'b0) begin n_err++; $display("FAIL reset_mid_tick got %h/%b want %h/0", date_out, new_day, pack(1, 1, 0)); end
  endtask

  task automatic test_dow();
`ifdef DATE_COUNTER_DOW_EN
    load(5, 5, 5, 6);
    n_cmp++; if (dow_out !== 3'd6) begin n_err++; $display("FAIL dow_load got %0d want 6", dow_out); end
    tick();
    n_cmp++; if (dow_out !== 3'd0 || date_out !== pack(6, 5, 5)) begin n_err++; $display("FAIL dow_wrap got %0d/%h want 0/%h", dow_out, date_out, pack(6, 5, 5)); end
    load(6, 6, 6, 7);
    n_cmp++; if (load_err !== 1'b1 || date_out !== pack(6, 5, 5) || dow_out !== 3'd0) begin n_err++; $display("FAIL dow_reject got %b/%h/%0d want 1/%h/0", load_err, date_out, dow_out, pack(6, 5, 5)); end
`else
    load(5, 5, 5, 7);
    n_cmp++; if (load_err !== 1'b0 || date_out !== pack(5, 5, 5)) begin n_err++; $display("FAIL dow_ignored got %b/%h want 0/%h", load_err, date_out, pack(5, 5, 5)); end
    tick();
    n_cmp++; if (dow_out !== 3'd0) begin n_err++; $display("FAIL dow_tied got %0d want 0", dow_out); end
`endif
  endtask

  initial begin
    test_reset();
    test_false_tick();
    test_first_tick();
    test_leap();
    test_year_wrap();
    test_load_err();
    test_load_tick_collision();
    test_back_to_back();
    test_reset_mid();
    test_dow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
